// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel 100 ms timer scheduler.
package timer_pkg;

    // Default channel count and duration width (duration counted in 100 ms ticks).
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    // Per-channel timer state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

endpackage : timer_pkg

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN state machine plus a down-counter of 100 ms ticks.
// Cancel beats load, load beats tick, so a reload never produces an expire.
module timer_channel #(
    parameter int CNT_W = timer_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic             cancel,
    input  logic [CNT_W-1:0] dur,
    output logic             busy,
    output logic             expire
);
    import timer_pkg::*;

    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             expire_reg, expire_next;

    // State, counter and expire pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            expire_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            expire_reg <= expire_next;
        end
    end

    // Next-state logic: cancel aborts silently, a load (re)starts the count,
    // ticks only count while running and not in the load cycle.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        expire_next = 1'b0;
        if (cancel) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (load) begin
            state_next = ST_RUN;
            cnt_next   = (dur == '0) ? CNT_W'(1) : dur;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (tick) begin
                        if (cnt_reg == CNT_W'(1)) begin
                            state_next  = ST_IDLE;
                            cnt_next    = '0;
                            expire_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg == ST_RUN);
    assign expire = expire_reg;

endmodule : timer_channel

// File: rtl/timer_scheduler.sv
// Fixed-priority start arbiter (lowest index wins) feeding NUM_CH timer channels.
module timer_scheduler #(
    parameter int NUM_CH = timer_pkg::NUM_CH,
    parameter int CNT_W  = timer_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_100ms,
    input  logic [NUM_CH-1:0]       start_req,
    input  logic [NUM_CH*CNT_W-1:0] start_dur,
    input  logic [NUM_CH-1:0]       cancel,
    output logic [NUM_CH-1:0]       start_ack,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expire
);
    import timer_pkg::*;

    logic [NUM_CH-1:0] ack_reg;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;

    // A request already being acked this cycle is still held by its requester,
    // so it must not win again; a cancelled channel sits out this cycle.
    assign eligible = start_req & ~ack_reg & ~cancel;

    // Isolate the lowest set bit: one grant per cycle, lowest index first.
    assign grant = eligible & (~eligible + NUM_CH'(1));

    // Grant pulse register: ack is visible in the cycle after the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg <= '0;
        end else begin
            ack_reg <= grant;
        end
    end

    assign start_ack = ack_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            timer_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .tick   (tick_100ms),
                .load   (grant[gi]),
                .cancel (cancel[gi]),
                .dur    (start_dur[gi*CNT_W +: CNT_W]),
                .busy   (busy[gi]),
                .expire (expire[gi])
            );
        end
    endgenerate

endmodule : timer_scheduler
